// File: rtl/morse_pkg.sv
// Shared definitions for the Morse front-end and morse_decoder: symbol codes
// carried on morse_signal and the classifier state encoding.
package morse_pkg;

    // Symbol codes, one-cycle strobes on morse_signal
    localparam logic [1:0] SYM_NONE = 2'b00;
    localparam logic [1:0] SYM_DOT  = 2'b01;
    localparam logic [1:0] SYM_DASH = 2'b10;
    localparam logic [1:0] SYM_GAP  = 2'b11;

    // Unit counter is 3 bits wide and saturates at its top value
    localparam int         UNIT_W   = 3;
    localparam logic [2:0] UNIT_MAX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_t;

endpackage

// File: rtl/morse_debounce.sv
// Key conditioning: 2-flop synchroniser for the asynchronous key, followed by
// an optional stability filter (enabled with MORSE_DEBOUNCE_EN).
module morse_debounce
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_f
);

    logic sync1;
    logic sync2;

    if (DEBOUNCE_CYCLES < 1) begin : g_param_check
        $error("morse_debounce: DEBOUNCE_CYCLES must be >= 1");
    end

    // Two-flop synchroniser, the only place key_in is sampled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

`ifdef MORSE_DEBOUNCE_EN
    localparam int            CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             key_q;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            key_q <= 1'b0;
        end else if (sync2 == key_q) begin
            cnt <= '0;
        end else if (cnt == CNT_TC) begin
            cnt   <= '0;
            key_q <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign key_f = key_q;
`else
    assign key_f = sync2;
`endif

endmodule

// File: rtl/morse_key_classifier.sv
// Morse key classifier: times filtered key marks and spaces in Morse units and
// emits one-cycle dot / dash / letter-gap codes plus a word-gap pulse.
// Optional key filter: define MORSE_DEBOUNCE_EN.
module morse_key_classifier
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES      = 1000,
    parameter int DASH_UNITS       = 2,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS   = 7,
    parameter int DEBOUNCE_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       key_in,
    output logic [1:0] morse_signal,
    output logic       word_gap,
    output logic       key_active
);

    localparam int              PW       = $clog2(UNIT_CYCLES);
    localparam logic [PW-1:0]   PRE_TC   = PW'(UNIT_CYCLES - 1);
    localparam logic [UNIT_W-1:0] DASH_U = UNIT_W'(DASH_UNITS);
    // Gap codes fire on the tick that moves the count onto the threshold
    localparam logic [UNIT_W-1:0] LGAP_PRE = UNIT_W'(LETTER_GAP_UNITS - 1);
    localparam logic [UNIT_W-1:0] WGAP_PRE = UNIT_W'(WORD_GAP_UNITS - 1);

    if (UNIT_CYCLES < 2 || WORD_GAP_UNITS <= LETTER_GAP_UNITS || WORD_GAP_UNITS > 7)
    begin : g_param_check
        $error("morse_key_classifier: illegal timing parameters");
    end

    logic              key_f;
    logic              key_q;
    logic              key_rise;
    logic              key_fall;
    logic              key_edge;
    logic              unit_tick;
    logic [PW-1:0]     pre;
    logic [UNIT_W-1:0] units;
    state_t            state;
    state_t            state_d;
    logic [1:0]        sym_d;
    logic              wgap_d;

    morse_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_in),
        .key_f  (key_f)
    );

    assign key_active = key_f;

    // Previous filtered level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_q <= 1'b0;
        else        key_q <= key_f;
    end

    assign key_rise  = key_f & ~key_q;
    assign key_fall  = ~key_f & key_q;
    assign key_edge  = key_f ^ key_q;
    // An edge restarts timing, so a coincident terminal count is not a unit
    assign unit_tick = (pre == PRE_TC) && !key_edge;

    // Unit prescaler, realigned to every key edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              pre <= '0;
        else if (!en || key_edge || pre == PRE_TC) pre <= '0;
        else                                     pre <= pre + 1'b1;
    end

    // Whole units since the last edge, saturating so long holds stay dashes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              units <= '0;
        else if (!en || key_edge)                units <= '0;
        else if (unit_tick && units != UNIT_MAX) units <= units + 1'b1;
    end

    // Next state and symbol decode
    always_comb begin
        state_d = state;
        sym_d   = SYM_NONE;
        wgap_d  = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_rise) state_d = ST_MARK;
                end
                ST_MARK: begin
                    if (key_fall) begin
                        sym_d   = (units < DASH_U) ? SYM_DOT : SYM_DASH;
                        state_d = ST_SPACE;
                    end
                end
                ST_SPACE: begin
                    if (key_rise) begin
                        state_d = ST_MARK;
                    end else if (unit_tick && units == WGAP_PRE) begin
                        wgap_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (unit_tick && units == LGAP_PRE) begin
                        sym_d = SYM_GAP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and registered symbol outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            morse_signal <= SYM_NONE;
            word_gap     <= 1'b0;
        end else begin
            state        <= state_d;
            morse_signal <= sym_d;
            word_gap     <= wgap_d;
        end
    end

endmodule

// File: tb/tb_morse_key_classifier.sv
// Bench for morse_key_classifier: duration-based reference model checked every
// cycle, plus per-scenario literal symbol counts and timing.
module tb_morse_key_classifier;

    localparam int U   = 4;
    localparam int DSH = 2;
    localparam int LG  = 3;
    localparam int WG  = 7;
    localparam int DEB = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       key_in;
    logic [1:0] morse_signal;
    logic       word_gap;
    logic       key_active;

    always #5 clk = ~clk;

    morse_key_classifier #(
        .UNIT_CYCLES      (U),
        .DASH_UNITS       (DSH),
        .LETTER_GAP_UNITS (LG),
        .WORD_GAP_UNITS   (WG),
        .DEBOUNCE_CYCLES  (DEB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .key_in       (key_in),
        .morse_signal (morse_signal),
        .word_gap     (word_gap),
        .key_active   (key_active)
    );

    typedef enum {M_IDLE, M_MARK, M_SPACE} mmode_t;

    // Monitor / model state
    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    bit     k  [4];
    bit     kf [3];
    bit     kf_new, rise, fall;
    int     run = 0;
    mmode_t mode = M_IDLE;
    int     t0 = 0;
    int     dur, ul;
    int     exp_sym;
    bit     exp_wg;
    int     cnt [4] = '{0, 0, 0, 0};
    int     base[4] = '{0, 0, 0, 0};
    int     last_ev[4] = '{0, 0, 0, 0};
    int     pin_done = 0;
    string  names[4] = '{"dot", "dash", "gap", "wgap"};

    // Written by the stimulus process only
    int     pin_req = 0;
    int     rel_cyc = 0;

    // Expected {dot, dash, gap, word_gap} counts per scenario
`ifdef MORSE_DEBOUNCE_EN
    localparam int LAT_EXTRA = DEB;
    int lit_tab[8][4] = '{'{1,0,1,1}, '{0,2,2,2}, '{2,0,1,1}, '{0,0,0,0},
                          '{0,1,1,1}, '{0,0,0,0}, '{1,0,0,0}, '{1,0,1,1}};
`else
    localparam int LAT_EXTRA = 0;
    int lit_tab[8][4] = '{'{1,0,1,1}, '{0,2,2,2}, '{2,0,1,1}, '{1,0,1,1},
                          '{0,1,1,1}, '{0,0,0,0}, '{1,0,0,0}, '{1,0,1,1}};
`endif

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model and compare, once per cycle after the active edge
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) k[i] = 1'b0;
            for (int i = 0; i < 3; i++) kf[i] = 1'b0;
            run = 0; mode = M_IDLE; exp_sym = 0; exp_wg = 1'b0;
        end else begin
            k[3] = k[2]; k[2] = k[1]; k[1] = k[0]; k[0] = key_in;
`ifdef MORSE_DEBOUNCE_EN
            kf_new = kf[0];
            if (k[2] != kf[0]) begin
                run++;
                if (run == DEB) begin kf_new = k[2]; run = 0; end
            end else run = 0;
`else
            kf_new = k[1];
`endif
            kf[2] = kf[1]; kf[1] = kf[0]; kf[0] = kf_new;
            rise = kf[1] & ~kf[2];
            fall = ~kf[1] & kf[2];
            exp_sym = 0; exp_wg = 1'b0;
            if (!en) mode = M_IDLE;
            else case (mode)
                M_IDLE: if (rise) begin mode = M_MARK; t0 = cyc; end
                M_MARK: if (fall) begin
                    dur = cyc - t0;
                    ul  = (dur - 1) / U;
                    if (ul > 7) ul = 7;
                    exp_sym = (ul < DSH) ? 1 : 2;
                    mode = M_SPACE; t0 = cyc;
                end
                M_SPACE: begin
                    if (rise) begin mode = M_MARK; t0 = cyc; end
                    else if (cyc - t0 == U * WG) begin exp_wg = 1'b1; mode = M_IDLE; end
                    else if (cyc - t0 == U * LG) exp_sym = 3;
                end
                default: mode = M_IDLE;
            endcase
        end
        chk("morse_signal", int'(morse_signal), exp_sym);
        chk("word_gap", int'(word_gap), int'(exp_wg));
        chk("key_active", int'(key_active), int'(kf[0]));

        if (morse_signal != 2'b00) begin
            cnt[int'(morse_signal) - 1]++;
            last_ev[int'(morse_signal) - 1] = cyc;
        end
        if (word_gap) begin cnt[3]++; last_ev[3] = cyc; end

        if (pin_req != pin_done) begin
            for (int f = 0; f < 4; f++)
                chk($sformatf("pin%0d_%s", pin_req, names[f]), cnt[f] - base[f],
                    lit_tab[pin_req - 1][f]);
            if (pin_req == 1) begin
                chk("dot_latency", last_ev[0] - rel_cyc, 3 + LAT_EXTRA);
                chk("gap_after_dot", last_ev[2] - last_ev[0], U * LG);
                chk("wgap_after_dot", last_ev[3] - last_ev[0], U * WG);
            end
            for (int f = 0; f < 4; f++) base[f] = cnt[f];
            pin_done = pin_req;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input int n);
        key_in = 1'b1;
        wait_cyc(n);
        key_in  = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic pin(input int p);
        pin_req = p;
        wait_cyc(2);
    endtask

    initial begin
        int pl, sl, r;
        rst_n = 1'b0; en = 1'b1; key_in = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(2);

        // Dot, letter gap, word gap
        press(5);  wait_cyc(40); pin(1);
        // Dashes, including the tick/edge boundary length
        press(12); wait_cyc(40);
        press(9);  wait_cyc(40); pin(2);
        // Short space: no letter gap, second mark normal
        press(5);  wait_cyc(8);
        press(5);  wait_cyc(40); pin(3);
        // Glitches vs short pulse
`ifdef MORSE_DEBOUNCE_EN
        for (int i = 0; i < 4; i++) begin
            key_in = 1'b1; wait_cyc(1);
            key_in = 1'b0; wait_cyc(5);
        end
        wait_cyc(40);
`else
        press(3);  wait_cyc(40);
`endif
        pin(4);
        // Long hold saturates to dash
        press(40); wait_cyc(40); pin(5);
        // Enable dropped mid-mark
        key_in = 1'b1; wait_cyc(3);
        en = 1'b0;     wait_cyc(3);
        key_in = 1'b0; wait_cyc(3);
        en = 1'b1;     wait_cyc(40); pin(6);
        // Reset mid-space
        press(3);  wait_cyc(6);
        rst_n = 1'b0; wait_cyc(2);
        rst_n = 1'b1; wait_cyc(40); pin(7);
        press(3);  wait_cyc(40); pin(8);

        // Randomised traffic
        for (int it = 0; it < 150; it++) begin
            pl = $urandom_range(1, 40);
            sl = $urandom_range(1, 40);
            r  = $urandom_range(0, 19);
            if (r == 0) begin
                key_in = 1'b1; wait_cyc(pl / 2 + 1);
                en = 1'b0;     wait_cyc(3);
                key_in = 1'b0; wait_cyc(2);
                en = 1'b1;     wait_cyc(sl);
            end else if (r == 1) begin
                press(pl); wait_cyc(sl / 2 + 1);
                rst_n = 1'b0; wait_cyc(2);
                rst_n = 1'b1; wait_cyc(sl);
            end else begin
                press(pl); wait_cyc(sl);
            end
        end
        wait_cyc(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
